ex_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline, directly downstream of instruction decode via the ID/EX register. Consumes decoded aluop/alusel/operands/destination, produces the logic and shift results single-cycle (also the EX forwarding source back to decode), and runs DIV/DIVU on a multi-cycle radix-2 divider. During a divide it holds the pipeline through a stall request to ctrl and delivers quotient/remainder toward MEM as a HI/LO write.

---
 rtl/ex_stage_pkg.sv | 39 +++
 rtl/ex_div.sv | 107 ++++++++++
 rtl/ex_stage.sv | 96 +++++++++
 tb/tb_ex_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared opcodes, result classes, bus widths and divider state encodings for the EX stage.
// The optional divider is selected by the EX_STAGE_DIV_EN macro in ex_stage.sv.
package ex_stage_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int ALUOP_W    = 8;
   localparam int ALUSEL_W   = 3;

   typedef logic [ALUOP_W-1:0]    alu_op_bus_t;
   typedef logic [ALUSEL_W-1:0]   alu_sel_bus_t;
   typedef logic [DATA_W-1:0]     reg_bus_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;

   localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
   localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
   localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
   localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
   localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
   localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
   localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
   localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
   localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

   localparam logic [2:0] EXE_RES_NOP   = 3'b000;
   localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

   localparam logic [1:0] DIV_IDLE = 2'b00;
   localparam logic [1:0] DIV_BUSY = 2'b01;
   localparam logic [1:0] DIV_DONE = 2'b10;

   // Two's-complement negate when neg is set; -0x8000_0000 stays 0x8000_0000, the correct magnitude.
   function automatic reg_bus_t negate_if(input reg_bus_t x, input logic neg);
      return neg ? (32'd0 - x) : x;
   endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: IDLE/BUSY/DONE FSM, counter, sign fix-up.
module ex_div
   import ex_stage_pkg::*;
#(
   parameter int DIV_ITER = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              signed_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic              stall_o,
   output logic              done_o,
   output logic [DATA_W-1:0] quot_o,
   output logic [DATA_W-1:0] rem_o
);

   localparam int CNT_W = $clog2(DIV_ITER + 1);

   logic [1:0]        state_q, state_d, state_nx;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] quot_q, quot_d, rem_q, rem_d, dvsr_q, dvsr_d;
   logic              negq_q, negq_d, negr_q, negr_d;
   logic [DATA_W+1:0] trial_s;
   logic              dvd_neg_s, dvs_neg_s;

   assign dvd_neg_s = signed_i & dividend_i[DATA_W-1];
   assign dvs_neg_s = signed_i & divisor_i[DATA_W-1];
   // Shift the next dividend bit into the partial remainder and try subtracting the divisor.
   assign trial_s   = {1'b0, rem_q, quot_q[DATA_W-1]} - {2'b00, dvsr_q};

   // Next-state and datapath update for the divider.
   always_comb begin
      state_nx = state_q;
      cnt_d    = cnt_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      dvsr_d   = dvsr_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      case (state_q)
         DIV_IDLE: begin
            if (start_i) begin
               if (divisor_i == 32'd0) begin
                  state_nx = DIV_DONE;
                  quot_d   = 32'd0;
                  rem_d    = 32'd0;
                  negq_d   = 1'b0;
                  negr_d   = 1'b0;
               end else begin
                  state_nx = DIV_BUSY;
                  quot_d   = negate_if(dividend_i, dvd_neg_s);
                  dvsr_d   = negate_if(divisor_i, dvs_neg_s);
                  rem_d    = 32'd0;
                  cnt_d    = '0;
                  negq_d   = dvd_neg_s ^ dvs_neg_s;
                  negr_d   = dvd_neg_s;
               end
            end else begin
               state_nx = DIV_IDLE;
            end
         end
         DIV_BUSY: begin
            quot_d = {quot_q[DATA_W-2:0], ~trial_s[DATA_W+1]};
            rem_d  = trial_s[DATA_W+1] ? {rem_q[DATA_W-2:0], quot_q[DATA_W-1]} : trial_s[DATA_W-1:0];
            cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
               state_nx = DIV_DONE;
            end else begin
               state_nx = DIV_BUSY;
            end
         end
         DIV_DONE: state_nx = DIV_IDLE;
         default:  state_nx = DIV_IDLE;
      endcase
      state_d = flush_i ? DIV_IDLE : state_nx;
   end

   // Divider state and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         quot_q  <= 32'd0;
         rem_q   <= 32'd0;
         dvsr_q  <= 32'd0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dvsr_q  <= dvsr_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
      end
   end

   assign stall_o = start_i & ~flush_i & (state_q != DIV_DONE);
   assign done_o  = (state_q == DIV_DONE);
   assign quot_o  = negate_if(quot_q, negq_q);
   assign rem_o   = negate_if(rem_q, negr_q);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: logic/shift ALU mux, stall/flush glue and optional divider.
// Define EX_STAGE_DIV_EN to compile in the DIV/DIVU divider; otherwise they act as NOPs.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int DIV_ITER = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ALUOP_W-1:0]    aluop_i,
   input  logic [ALUSEL_W-1:0]   alusel_i,
   input  logic [DATA_W-1:0]     reg1_i,
   input  logic [DATA_W-1:0]     reg2_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic                  flush_i,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic                  wreg_o,
   output logic [DATA_W-1:0]     wdata_o,
   output logic                  whilo_o,
   output logic [DATA_W-1:0]     hi_o,
   output logic [DATA_W-1:0]     lo_o,
   output logic                  stallreq_o
);

   logic [DATA_W-1:0] alu_res_s;
   logic [4:0]        shamt_s;
   logic              is_div_s;
   logic              div_stall_s, div_done_s;
   logic [DATA_W-1:0] div_quot_s, div_rem_s;
   logic              whilo_s;

   assign shamt_s  = reg1_i[4:0];
   assign is_div_s = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

   // Single-cycle result selection; this also feeds the EX forwarding path.
   always_comb begin
      alu_res_s = 32'd0;
      case (alusel_i)
         EXE_RES_LOGIC: begin
            case (aluop_i)
               EXE_OR_OP:  alu_res_s = reg1_i | reg2_i;
               EXE_AND_OP: alu_res_s = reg1_i & reg2_i;
               EXE_XOR_OP: alu_res_s = reg1_i ^ reg2_i;
               EXE_NOR_OP: alu_res_s = ~(reg1_i | reg2_i);
               default:    alu_res_s = 32'd0;
            endcase
         end
         EXE_RES_SHIFT: begin
            case (aluop_i)
               EXE_SLL_OP: alu_res_s = reg2_i << shamt_s;
               EXE_SRL_OP: alu_res_s = reg2_i >> shamt_s;
               EXE_SRA_OP: alu_res_s = $unsigned($signed(reg2_i) >>> shamt_s);
               default:    alu_res_s = 32'd0;
            endcase
         end
         default: alu_res_s = 32'd0;
      endcase
   end

`ifdef EX_STAGE_DIV_EN
   ex_div #(
      .DIV_ITER(DIV_ITER)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .start_i   (is_div_s),
      .signed_i  (aluop_i == EXE_DIV_OP),
      .flush_i   (flush_i),
      .dividend_i(reg1_i),
      .divisor_i (reg2_i),
      .stall_o   (div_stall_s),
      .done_o    (div_done_s),
      .quot_o    (div_quot_s),
      .rem_o     (div_rem_s)
   );
`else
   logic unused_div_s;
   assign unused_div_s = ^{clk, flush_i};
   assign div_stall_s  = 1'b0;
   assign div_done_s   = 1'b0;
   assign div_quot_s   = 32'd0;
   assign div_rem_s    = 32'd0;
`endif

   // Outputs are forced to zero while reset is asserted, even the combinational ones.
   assign whilo_s    = rst & is_div_s & div_done_s & ~flush_i;
   assign whilo_o    = whilo_s;
   assign lo_o       = whilo_s ? div_quot_s : 32'd0;
   assign hi_o       = whilo_s ? div_rem_s : 32'd0;
   assign stallreq_o = rst & div_stall_s;
   assign wd_o       = rst ? wd_i : 5'd0;
   assign wreg_o     = rst & wreg_i & ~is_div_s;
   assign wdata_o    = rst ? alu_res_s : 32'd0;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; divide checks follow the EX_STAGE_DIV_EN build option.
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i, reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i, flush_i;
   logic [4:0]  wd_o;
   logic        wreg_o, whilo_o, stallreq_o;
   logic [31:0] wdata_o, hi_o, lo_o;

   int n_asrt = 0;
   int n_fail = 0;

   ex_stage dut (
      .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
      .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [4:0] wd, input logic wr);
      aluop_i  = op;
      alusel_i = sel;
      reg1_i   = r1;
      reg2_i   = r2;
      wd_i     = wd;
      wreg_i   = wr;
      #1;
   endtask

   // Counts stall cycles from the issue cycle; leaves the bench in the first non-stalled cycle.
   task automatic count_stall(output int n);
      n = 0;
      while (stallreq_o === 1'b1 && n < 40) begin
         n++;
         cyc();
      end
   endtask

   int n_st;
   int pulses;

   initial begin
      rst     = 1'b0;
      flush_i = 1'b0;
      apply(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_1100, 32'h0000_0020, 5'd3, 1'b1);
      chk("rst_wdata", wdata_o, 32'd0);
      chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
      chk("rst_wd", {27'd0, wd_o}, 32'd0);
      chk("rst_whilo", {31'd0, whilo_o}, 32'd0);
      cyc();
      cyc();
      rst = 1'b1;
      #1;
      chk("ori_wdata", wdata_o, 32'h0000_1120);
      chk("ori_wreg", {31'd0, wreg_o}, 32'd1);
      chk("ori_wd", {27'd0, wd_o}, 32'd3);
      chk("ori_stall", {31'd0, stallreq_o}, 32'd0);

      apply(EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd4, 1'b1);
      chk("and", wdata_o, 32'h00F0_1200);
      apply(EXE_XOR_OP, EXE_RES_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 5'd4, 1'b1);
      chk("xor", wdata_o, 32'h5555_5555);
      apply(EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_00F0, 32'h0000_000F, 5'd4, 1'b1);
      chk("nor", wdata_o, 32'hFFFF_FF00);
      apply(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 5'd5, 1'b1);
      chk("sra", wdata_o, 32'hF800_0000);
      apply(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 5'd5, 1'b1);
      chk("srl", wdata_o, 32'h0800_0000);
      apply(EXE_SLL_OP, EXE_RES_SHIFT, 32'h0000_0024, 32'h8000_0001, 5'd5, 1'b1);
      chk("sll_shamt5", wdata_o, 32'h0000_0010);
      apply(EXE_SRA_OP, EXE_RES_SHIFT, 32'd31, 32'h7FFF_FFFF, 5'd5, 1'b1);
      chk("sra_pos31", wdata_o, 32'd0);
      apply(EXE_OR_OP, EXE_RES_NOP, 32'h1234_5678, 32'h1, 5'd6, 1'b1);
      chk("nop_class", wdata_o, 32'd0);
      apply(EXE_OR_OP, 3'b111, 32'h1234_5678, 32'h1, 5'd6, 1'b1);
      chk("unknown_sel", wdata_o, 32'd0);
      apply(EXE_SLL_OP, EXE_RES_LOGIC, 32'h1234_5678, 32'h1, 5'd6, 1'b1);
      chk("unknown_logic_op", wdata_o, 32'd0);
      chk("nondiv_whilo", {31'd0, whilo_o}, 32'd0);
      chk("nondiv_hi", hi_o, 32'd0);
      cyc();

`ifdef EX_STAGE_DIV_EN
      // DIVU 100/7, then DIV -7/2 issued back-to-back in the cycle after DONE.
      apply(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd7, 1'b1);
      chk("divu_wreg", {31'd0, wreg_o}, 32'd0);
      count_stall(n_st);
      chk("divu_stall_cycles", n_st, 32'd33);
      chk("divu_whilo", {31'd0, whilo_o}, 32'd1);
      chk("divu_lo", lo_o, 32'd14);
      chk("divu_hi", hi_o, 32'd2);
      chk("divu_wreg_done", {31'd0, wreg_o}, 32'd0);
      cyc();
      apply(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1);
      count_stall(n_st);
      chk("div_b2b_stall_cycles", n_st, 32'd33);
      chk("div_neg_lo", lo_o, 32'hFFFF_FFFD);
      chk("div_neg_hi", hi_o, 32'hFFFF_FFFF);
      cyc();

      apply(EXE_DIV_OP, EXE_RES_NOP, 32'd5, 32'd0, 5'd7, 1'b1);
      chk("div0_stall", {31'd0, stallreq_o}, 32'd1);
      cyc();
      chk("div0_stall_done", {31'd0, stallreq_o}, 32'd0);
      chk("div0_whilo", {31'd0, whilo_o}, 32'd1);
      chk("div0_lo", lo_o, 32'd0);
      chk("div0_hi", hi_o, 32'd0);
      cyc();

      // Reset at BUSY cycle 10.
      apply(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd7, 1'b1);
      for (int i = 0; i < 11; i++) cyc();
      chk("pre_rst_stall", {31'd0, stallreq_o}, 32'd1);
      rst = 1'b0;
      #1;
      chk("midrst_stall", {31'd0, stallreq_o}, 32'd0);
      chk("midrst_whilo", {31'd0, whilo_o}, 32'd0);
      chk("midrst_lo", lo_o, 32'd0);
      chk("midrst_wd", {27'd0, wd_o}, 32'd0);
      cyc();
      rst = 1'b1;
      #1;
      count_stall(n_st);
      chk("post_rst_stall_cycles", n_st, 32'd33);
      chk("post_rst_lo", lo_o, 32'd14);
      cyc();

      // Flush at BUSY cycle 10, and flush beating a fresh issue.
      apply(EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd7, 1'b1);
      for (int i = 0; i < 11; i++) cyc();
      flush_i = 1'b1;
      #1;
      chk("flush_stall", {31'd0, stallreq_o}, 32'd0);
      chk("flush_whilo", {31'd0, whilo_o}, 32'd0);
      cyc();
      flush_i = 1'b0;
      apply(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         if (whilo_o === 1'b1) pulses++;
         cyc();
      end
      chk("flush_no_whilo", pulses, 32'd0);
      apply(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1);
      flush_i = 1'b1;
      #1;
      chk("flush_issue_stall", {31'd0, stallreq_o}, 32'd0);
      cyc();
      flush_i = 1'b0;
      #1;
      count_stall(n_st);
      chk("post_flush_stall_cycles", n_st, 32'd33);
      chk("post_flush_lo", lo_o, 32'hFFFF_FFFD);
      chk("post_flush_hi", hi_o, 32'hFFFF_FFFF);
      cyc();
`else
      apply(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd7, 1'b1);
      chk("nodiv_stall", {31'd0, stallreq_o}, 32'd0);
      chk("nodiv_wreg", {31'd0, wreg_o}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 36; i++) begin
         if (whilo_o === 1'b1 || stallreq_o === 1'b1) pulses++;
         cyc();
      end
      chk("nodiv_no_activity", pulses, 32'd0);
      chk("nodiv_lo", lo_o, 32'd0);
      chk("nodiv_hi", hi_o, 32'd0);
      apply(EXE_DIV_OP, EXE_RES_NOP, 32'd5, 32'd0, 5'd7, 1'b1);
      cyc();
      chk("nodiv0_whilo", {31'd0, whilo_o}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
